pass_vault_ctrl: RTL and testbench

- Parametrised successor of the single-entry password-keeper top level.
- Holds a DEPTH-entry table of {account tag, encrypted password}, boot-loads it from external flash and serves GET (lookup + decrypt) and PUT (encrypt + insert/overwrite) requests.
- Persists every PUT back to flash.
- Drives an external AES-style cipher engine over a req/ack handshake instead of embedding it.

---
 rtl/pass_vault_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_pass_vault_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pass_vault_ctrl.sv
// Password vault controller: DEPTH-entry {tag, ciphertext} table, flash boot/persist, external cipher.
// Optional zeroize port and logic enabled by defining PASS_VAULT_ZEROIZE_EN.
module pass_vault_ctrl #(
  parameter int unsigned ACC_W  = 128,
  parameter int unsigned PW_W   = 128,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W:0]         boot_count,
  input  logic                    go,
`ifdef PASS_VAULT_ZEROIZE_EN
  input  logic                    zeroize,
`endif
  input  logic                    op,
  input  logic [ACC_W-1:0]        account,
  input  logic [PW_W-1:0]         password,
  input  logic [PW_W-1:0]         master_key,
  output logic                    ready,
  output logic                    done,
  output logic [1:0]              status,
  output logic [PW_W-1:0]         pw_out,
  output logic                    cipher_req,
  output logic                    cipher_dec,
  output logic [PW_W-1:0]         cipher_key,
  output logic [PW_W-1:0]         cipher_din,
  input  logic                    cipher_ack,
  input  logic [PW_W-1:0]         cipher_dout,
  output logic [ADDR_W-1:0]       flash_addr,
  input  logic [ACC_W+PW_W-1:0]   flash_rd_data,
  output logic                    flash_wr_en,
  output logic [ACC_W+PW_W-1:0]   flash_wr_data
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned ENT_W = ACC_W + PW_W;

  localparam logic [1:0] ST_HIT  = 2'd0;
  localparam logic [1:0] ST_NEW  = 2'd1;
  localparam logic [1:0] ST_MISS = 2'd2;
  localparam logic [1:0] ST_FULL = 2'd3;

  typedef enum logic [3:0] {
    BOOT, BOOT_WAIT, READY, SEARCH, ENC_REQ, ENC_WAIT, WRITE, DONE, ZERO
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0]  boot_n;
  logic [CNT_W-1:0]  count, count_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [ADDR_W-1:0] tgt, tgt_n;
  logic              op_q, op_n;
  logic [ACC_W-1:0]  acc_q, acc_n;
  logic [PW_W-1:0]   pw_q, pw_n;
  logic [PW_W-1:0]   key_q, key_n;
  logic [1:0]        st_q, st_n;
  logic              wr_q, wr_n;

  logic              ready_n, done_n, cipher_req_n, cipher_dec_n, flash_wr_en_n;
  logic [1:0]        status_n;
  logic [PW_W-1:0]   pw_out_n, cipher_key_n, cipher_din_n;
  logic [ADDR_W-1:0] flash_addr_n;
  logic [ENT_W-1:0]  flash_wr_data_n;

  logic [ACC_W-1:0]  tags [DEPTH];
  logic [PW_W-1:0]   cts  [DEPTH];

  logic              tbl_we;
  logic [ADDR_W-1:0] tbl_idx;
  logic [ACC_W-1:0]  tbl_tag;
  logic [PW_W-1:0]   tbl_ct;

  logic              hit, last;

  assign hit  = (count != '0) && (tags[idx] == acc_q);
  assign last = ({1'b0, idx} == (count - CNT_W'(1)));

  // Table storage: single write port shared by boot load, PUT update and zeroize
  always_ff @(posedge clk) begin
    if (rst && tbl_we) begin
      tags[tbl_idx] <= tbl_tag;
      cts[tbl_idx]  <= tbl_ct;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= BOOT;
      boot_n        <= (boot_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : boot_count;
      count         <= '0;
      idx           <= '0;
      tgt           <= '0;
      op_q          <= 1'b0;
      acc_q         <= '0;
      pw_q          <= '0;
      key_q         <= '0;
      st_q          <= ST_HIT;
      wr_q          <= 1'b0;
      ready         <= 1'b0;
      done          <= 1'b0;
      status        <= '0;
      pw_out        <= '0;
      cipher_req    <= 1'b0;
      cipher_dec    <= 1'b0;
      cipher_key    <= '0;
      cipher_din    <= '0;
      flash_addr    <= '0;
      flash_wr_en   <= 1'b0;
      flash_wr_data <= '0;
    end else begin
      state         <= state_n;
      count         <= count_n;
      idx           <= idx_n;
      tgt           <= tgt_n;
      op_q          <= op_n;
      acc_q         <= acc_n;
      pw_q          <= pw_n;
      key_q         <= key_n;
      st_q          <= st_n;
      wr_q          <= wr_n;
      ready         <= ready_n;
      done          <= done_n;
      status        <= status_n;
      pw_out        <= pw_out_n;
      cipher_req    <= cipher_req_n;
      cipher_dec    <= cipher_dec_n;
      cipher_key    <= cipher_key_n;
      cipher_din    <= cipher_din_n;
      flash_addr    <= flash_addr_n;
      flash_wr_en   <= flash_wr_en_n;
      flash_wr_data <= flash_wr_data_n;
    end
  end

  // Next-state and next-output logic; registered outputs follow the state they enter
  always_comb begin
    state_n         = state;
    count_n         = count;
    idx_n           = idx;
    tgt_n           = tgt;
    op_n            = op_q;
    acc_n           = acc_q;
    pw_n            = pw_q;
    key_n           = key_q;
    st_n            = st_q;
    wr_n            = wr_q;
    ready_n         = 1'b0;
    done_n          = 1'b0;
    status_n        = status;
    pw_out_n        = pw_out;
    cipher_req_n    = cipher_req;
    cipher_dec_n    = cipher_dec;
    cipher_key_n    = cipher_key;
    cipher_din_n    = cipher_din;
    flash_addr_n    = flash_addr;
    flash_wr_en_n   = 1'b0;
    flash_wr_data_n = flash_wr_data;
    tbl_we          = 1'b0;
    tbl_idx         = idx;
    tbl_tag         = acc_q;
    tbl_ct          = cipher_dout;

    unique case (state)
      BOOT: begin
        if (boot_n == '0) begin
          state_n = READY;
          ready_n = 1'b1;
        end else begin
          state_n = BOOT_WAIT;
        end
      end

      // flash_addr has been stable for a full cycle, so read data is valid now
      BOOT_WAIT: begin
        tbl_we              = 1'b1;
        tbl_idx             = count[ADDR_W-1:0];
        {tbl_tag, tbl_ct}   = flash_rd_data;
        count_n             = count + CNT_W'(1);
        flash_addr_n        = ADDR_W'(count_n);
        if (count_n == boot_n) begin
          state_n = READY;
          ready_n = 1'b1;
        end else begin
          state_n = BOOT;
        end
      end

      READY: begin
        ready_n = 1'b1;
`ifdef PASS_VAULT_ZEROIZE_EN
        if (zeroize) begin
          ready_n         = 1'b0;
          count_n         = '0;
          pw_out_n        = '0;
          idx_n           = '0;
          flash_addr_n    = '0;
          flash_wr_data_n = '0;
          flash_wr_en_n   = 1'b1;
          state_n         = ZERO;
        end else
`endif
        if (go) begin
          ready_n = 1'b0;
          op_n    = op;
          acc_n   = account;
          pw_n    = password;
          key_n   = master_key;
          idx_n   = '0;
          state_n = SEARCH;
        end
      end

      SEARCH: begin
        if (hit || count == '0 || last) begin
          if (hit) begin
            tgt_n = idx;
            st_n  = ST_HIT;
            wr_n  = 1'b1;
          end else if (count == CNT_W'(DEPTH)) begin
            tgt_n = count[ADDR_W-1:0];
            st_n  = ST_FULL;
            wr_n  = 1'b0;
          end else begin
            tgt_n = count[ADDR_W-1:0];
            st_n  = ST_NEW;
            wr_n  = 1'b1;
          end
          if (!op_q && !hit) begin
            state_n  = DONE;
            done_n   = 1'b1;
            status_n = ST_MISS;
          end else begin
            state_n      = ENC_REQ;
            cipher_req_n = 1'b1;
            cipher_dec_n = ~op_q;
            cipher_key_n = key_q;
            cipher_din_n = op_q ? pw_q : cts[idx];
          end
        end else begin
          idx_n = idx + ADDR_W'(1);
        end
      end

      ENC_REQ: state_n = ENC_WAIT;

      ENC_WAIT: begin
        if (cipher_ack) begin
          cipher_req_n = 1'b0;
          if (!op_q) begin
            pw_out_n = cipher_dout;
            state_n  = DONE;
            done_n   = 1'b1;
            status_n = ST_HIT;
          end else if (wr_q) begin
            tbl_we          = 1'b1;
            tbl_idx         = tgt;
            if (st_q == ST_NEW) count_n = count + CNT_W'(1);
            flash_wr_en_n   = 1'b1;
            flash_addr_n    = tgt;
            flash_wr_data_n = {acc_q, cipher_dout};
            state_n         = WRITE;
          end else begin
            state_n  = DONE;
            done_n   = 1'b1;
            status_n = st_q;
          end
        end
      end

      WRITE: begin
        state_n  = DONE;
        done_n   = 1'b1;
        status_n = st_q;
      end

      DONE: begin
        state_n = READY;
        ready_n = 1'b1;
      end

`ifdef PASS_VAULT_ZEROIZE_EN
      // One zero write per cycle; flash write strobe stays high across all DEPTH entries
      ZERO: begin
        tbl_we  = 1'b1;
        tbl_tag = '0;
        tbl_ct  = '0;
        if (idx == ADDR_W'(DEPTH - 1)) begin
          state_n  = DONE;
          done_n   = 1'b1;
          status_n = ST_HIT;
        end else begin
          idx_n         = idx + ADDR_W'(1);
          flash_addr_n  = idx + ADDR_W'(1);
          flash_wr_en_n = 1'b1;
        end
      end
`endif

      default: state_n = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pass_vault_ctrl.sv
// Scoreboard bench for pass_vault_ctrl: flash and cipher models, expected-response queues.
`timescale 1ns/1ps
module tb_pass_vault_ctrl;

  localparam int unsigned ACC_W  = 128;
  localparam int unsigned PW_W   = 128;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned ENT_W  = ACC_W + PW_W;

  localparam logic [1:0] S_HIT  = 2'd0;
  localparam logic [1:0] S_NEW  = 2'd1;
  localparam logic [1:0] S_MISS = 2'd2;
  localparam logic [1:0] S_FULL = 2'd3;

  localparam logic [PW_W-1:0] KEY = 128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W:0]   boot_count;
  logic              go;
`ifdef PASS_VAULT_ZEROIZE_EN
  logic              zeroize;
`endif
  logic              op;
  logic [ACC_W-1:0]  account;
  logic [PW_W-1:0]   password;
  logic [PW_W-1:0]   master_key;
  logic              ready, done;
  logic [1:0]        status;
  logic [PW_W-1:0]   pw_out;
  logic              cipher_req, cipher_dec;
  logic [PW_W-1:0]   cipher_key, cipher_din;
  logic              cipher_ack;
  logic [PW_W-1:0]   cipher_dout;
  logic [ADDR_W-1:0] flash_addr;
  logic [ENT_W-1:0]  flash_rd_data;
  logic              flash_wr_en;
  logic [ENT_W-1:0]  flash_wr_data;

  always #5 clk = ~clk;

  pass_vault_ctrl #(.ACC_W(ACC_W), .PW_W(PW_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .boot_count(boot_count), .go(go),
`ifdef PASS_VAULT_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .op(op), .account(account), .password(password), .master_key(master_key),
    .ready(ready), .done(done), .status(status), .pw_out(pw_out),
    .cipher_req(cipher_req), .cipher_dec(cipher_dec), .cipher_key(cipher_key),
    .cipher_din(cipher_din), .cipher_ack(cipher_ack), .cipher_dout(cipher_dout),
    .flash_addr(flash_addr), .flash_rd_data(flash_rd_data),
    .flash_wr_en(flash_wr_en), .flash_wr_data(flash_wr_data)
  );

  typedef struct packed { logic [1:0] st; logic [PW_W-1:0] pw; } resp_t;
  typedef struct packed { logic [ADDR_W-1:0] addr; logic [ENT_W-1:0] data; } fwr_t;
  typedef struct packed { logic dec; logic [PW_W-1:0] din; } cip_t;

  resp_t resp_q[$];
  fwr_t  fwr_q[$];
  cip_t  cip_q[$];

  int checks = 0;
  int errors = 0;
  int ack_delay = 2;
  logic [PW_W-1:0]  exp_pw;
  logic [ENT_W-1:0] fmem [DEPTH];

  function automatic logic [ACC_W-1:0] tag_of(input int i);
    return {32'hACC0_5EED, 64'h0, 32'(i)};
  endfunction

  function automatic logic [PW_W-1:0] pw_of(input int i);
    logic [31:0] w;
    w = 32'(i * 7 + 3) ^ 32'h5A5A_0000;
    return {w, ~w, w, ~w};
  endfunction

  // Toy cipher: rotate-left-8 then xor key; decrypt is the exact inverse
  function automatic logic [PW_W-1:0] cipher_fn(input logic [PW_W-1:0] d, input logic [PW_W-1:0] k,
                                               input logic dec);
    logic [PW_W-1:0] t;
    if (dec) begin
      t = d ^ k;
      return {t[7:0], t[PW_W-1:8]};
    end
    return {d[PW_W-9:0], d[PW_W-1:PW_W-8]} ^ k;
  endfunction

  function automatic logic [PW_W-1:0] enc(input logic [PW_W-1:0] x);
    return cipher_fn(x, KEY, 1'b0);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Flash: read data reflects the address presented in the previous cycle
  initial begin
    logic [ADDR_W-1:0] a;
    flash_rd_data = '0;
    forever begin
      @(posedge clk);
      a = flash_addr;
      #1 flash_rd_data = fmem[a];
    end
  end

  // Cipher responder; checks the request against the scoreboard when it answers
  initial begin
    int wcnt;
    bit sent;
    cip_t c;
    wcnt = 0;
    sent = 1'b0;
    cipher_ack  = 1'b0;
    cipher_dout = '0;
    forever begin
      @(negedge clk);
      cipher_ack = 1'b0;
      if (cipher_req !== 1'b1) begin
        sent = 1'b0;
        wcnt = 0;
      end else if (!sent) begin
        if (wcnt >= ack_delay) begin
          sent        = 1'b1;
          cipher_dout = cipher_fn(cipher_din, cipher_key, cipher_dec);
          cipher_ack  = 1'b1;
          if (cip_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cipher_req: got din %h expected no request", cipher_din);
          end else begin
            c = cip_q.pop_front();
            check("cipher_dec", 256'(cipher_dec), 256'(c.dec));
            check("cipher_din", 256'(cipher_din), 256'(c.din));
            check("cipher_key", 256'(cipher_key), 256'(KEY));
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Output monitor: done responses and flash writes against the scoreboard
  initial begin
    resp_t r;
    fwr_t  f;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got status %0d expected no done", status);
        end else begin
          r = resp_q.pop_front();
          check("done_status", 256'(status), 256'(r.st));
          check("done_pw_out", 256'(pw_out), 256'(r.pw));
        end
      end
      if (flash_wr_en === 1'b1) begin
        if (fwr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_flash_wr: got addr %0d expected no write", flash_addr);
        end else begin
          f = fwr_q.pop_front();
          check("flash_addr", 256'(flash_addr), 256'(f.addr));
          check("flash_wr_data", 256'(flash_wr_data), 256'(f.data));
        end
      end
    end
  end

  task automatic do_reset(input int bc, input int exp_cyc);
    int n;
    n = 0;
    @(negedge clk);
    rst = 1'b0;
    go = 1'b0;
    boot_count = (ADDR_W+1)'(bc);
    @(negedge clk);
    check("reset_ctrl", 256'({ready, done, status, cipher_req, cipher_dec, flash_wr_en, flash_addr}), 256'(0));
    check("reset_pw_out", 256'(pw_out), 256'(0));
    check("reset_cipher_bus", 256'({cipher_key, cipher_din}), 256'(0));
    check("reset_flash_wr_data", 256'(flash_wr_data), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    exp_pw = '0;
    do begin
      @(negedge clk);
      n++;
    end while (ready !== 1'b1 && n < 100);
    check("ready_after_boot", 256'(n), 256'(exp_cyc));
  endtask

  task automatic issue(input logic o, input logic [ACC_W-1:0] t, input logic [PW_W-1:0] p);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=0 after %0d cycles expected 1", n);
      return;
    end
    go = 1'b1;
    op = o;
    account = t;
    password = p;
    master_key = KEY;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 400);
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
    end
  endtask

  task automatic get_req(input logic [ACC_W-1:0] t, input bit hit, input logic [PW_W-1:0] pt);
    if (hit) begin
      cip_q.push_back('{dec: 1'b1, din: enc(pt)});
      exp_pw = pt;
      resp_q.push_back('{st: S_HIT, pw: exp_pw});
    end else begin
      resp_q.push_back('{st: S_MISS, pw: exp_pw});
    end
    issue(1'b0, t, '0);
    wait_done("get");
  endtask

  task automatic put_req(input logic [ACC_W-1:0] t, input logic [PW_W-1:0] pt,
                         input logic [1:0] st, input int addr);
    cip_q.push_back('{dec: 1'b0, din: pt});
    if (st != S_FULL) fwr_q.push_back('{addr: ADDR_W'(addr), data: {t, enc(pt)}});
    resp_q.push_back('{st: st, pw: exp_pw});
    issue(1'b1, t, pt);
    wait_done("put");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    go = 1'b0;
    op = 1'b0;
    account = '0;
    password = '0;
    master_key = KEY;
    boot_count = '0;
`ifdef PASS_VAULT_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    exp_pw = '0;
    for (int i = 0; i < int'(DEPTH); i++) fmem[i] = {tag_of(i), enc(pw_of(i))};

    // Boot three entries, slow cipher GET, then a miss that must keep pw_out
    ack_delay = 5;
    do_reset(3, 6);
    get_req(tag_of(1), 1'b1, pw_of(1));
    get_req(tag_of(77), 1'b0, '0);
    ack_delay = 2;

    // Empty table: PUT lands at 0, then reads back
    do_reset(0, 1);
    put_req(tag_of(60), {16{8'h11}}, S_NEW, 0);
    get_req(tag_of(60), 1'b1, {16{8'h11}});

    // Overwrite existing entry; next new tag appends at index 3
    do_reset(3, 6);
    put_req(tag_of(1), 128'hdead_beef_0123_4567_89ab_cdef_f00d_cafe, S_HIT, 1);
    get_req(tag_of(1), 1'b1, 128'hdead_beef_0123_4567_89ab_cdef_f00d_cafe);
    put_req(tag_of(40), pw_of(40), S_NEW, 3);
    get_req(tag_of(40), 1'b1, pw_of(40));

    // Oversized boot_count clips to a full table
    do_reset(20, 32);
    put_req(tag_of(50), pw_of(50), S_FULL, 0);
    get_req(tag_of(15), 1'b1, pw_of(15));
    get_req(tag_of(50), 1'b0, '0);
    get_req(tag_of(0), 1'b1, pw_of(0));

    // Reset while waiting on the cipher aborts the request
    do_reset(3, 6);
    ack_delay = 1000;
    issue(1'b0, tag_of(0), '0);
    n = 0;
    while (cipher_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_req_seen", 256'(cipher_req), 256'(1));
    repeat (2) @(negedge clk);
    do_reset(3, 6);
    ack_delay = 2;

    // go pulses during SEARCH are ignored
    cip_q.push_back('{dec: 1'b1, din: enc(pw_of(2))});
    exp_pw = pw_of(2);
    resp_q.push_back('{st: S_HIT, pw: exp_pw});
    issue(1'b0, tag_of(2), '0);
    go = 1'b1;
    op = 1'b1;
    account = tag_of(99);
    password = pw_of(99);
    repeat (2) @(negedge clk);
    go = 1'b0;
    wait_done("search_go");
    get_req(tag_of(99), 1'b0, '0);

`ifdef PASS_VAULT_ZEROIZE_EN
    // Zeroize wins over a simultaneous go and wipes the table
    for (int i = 0; i < int'(DEPTH); i++) fwr_q.push_back('{addr: ADDR_W'(i), data: '0});
    exp_pw = '0;
    resp_q.push_back('{st: S_HIT, pw: '0});
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    zeroize = 1'b1;
    go = 1'b1;
    op = 1'b0;
    account = tag_of(0);
    @(negedge clk);
    zeroize = 1'b0;
    go = 1'b0;
    wait_done("zeroize");
    get_req(tag_of(0), 1'b0, '0);
    get_req(tag_of(2), 1'b0, '0);
`endif

    repeat (5) @(negedge clk);
    check("resp_q_drained", 256'(resp_q.size()), 256'(0));
    check("fwr_q_drained", 256'(fwr_q.size()), 256'(0));
    check("cip_q_drained", 256'(cip_q.size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
